instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle RV32I core. Sits directly upstream of the combinational instruction memory.
- Owns the PC and drives the word-aligned byte address to instruction memory.
- Latches the returned word into an instruction register (IR) and presents it to the control/decode FSM with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0)

Ports:
clk  input  1  core clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  permits starting a new fetch
imem_addr  output  32  byte address to instruction memory (= pc_q, combinational)
imem_data  input  32  instruction word returned combinationally by memory
instr  output  32  IR contents
instr_pc  output  32  PC of the instruction in IR
instr_pc_plus4  output  32  instr_pc + 4, for JAL/JALR link
instr_valid  output  1  IR holds an unconsumed instruction
instr_ready  input  1  consumer accepts IR this cycle
redirect_valid  input  1  redirect PC request (branch taken / jump)
redirect_pc  input  32  redirect target byte address

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset values (asynchronous on rst_n low):
  - state=IDLE, pc_q=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0.
  - imem_addr follows pc_q, so it equals RESET_PC.
- State machine: IDLE, FETCH, VALID (plus FAULT with the optional feature).
- IDLE:
  - If fetch_en=1, go to FETCH next cycle.
  - Otherwise hold.
- FETCH:
  - Memory is combinational. At the clock edge, IR<=imem_data, instr_pc<=pc_q, then go to VALID.
  - Latency: one cycle from entering FETCH to instr_valid=1.
- VALID:
  - instr_valid=1. IR and instr_pc are stable while instr_ready=0.
  - On instr_valid & instr_ready: pc_q<=pc_q+4. Go to FETCH if fetch_en=1, else IDLE.
- Redirect:
  - redirect_valid=1 in any state: pc_q<=redirect_pc, state<=FETCH (or IDLE if fetch_en=0), instr_valid drops next cycle.
  - Redirect has priority over the +4 increment. If it coincides with a handshake in VALID, the IR instruction counts as consumed and the increment is discarded.
  - redirect_pc[1:0] is forced to 2'b00 (without the optional feature).
- Arithmetic:
  - pc_q+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
  - imem_addr carries the full 32 bits. Address aliasing above 4KB is the memory's concern.
- fetch_en deasserted in FETCH: the in-flight fetch completes into VALID. fetch_en gates only new fetches.
- instr_valid never deasserts without a handshake or a redirect.
- Reset mid-operation: immediate return to reset values. No partial IR update.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output port fetch_fault (1 bit, reset 0) and state FAULT.
  - A redirect with redirect_pc[1:0]!=0 loads pc_q with the unmodified target, enters FAULT, and sets fetch_fault=1. instr_valid=0 in FAULT.
  - FAULT is left only via an aligned redirect (goes to FETCH/IDLE, fetch_fault<=0) or reset.
- Disabled: no fetch_fault port, no FAULT state; low bits are silently cleared.

Decomposition:
- Package fetch_pkg: fetch_state_e enum (IDLE, FETCH, VALID, FAULT), NOP_INSTR constant, default RESET_PC.
- Sub-module fetch_pc_reg: PC register with next-PC mux (hold / +4 / redirect), async reset to RESET_PC, pc_plus4 output.
- The FSM and IR remain in instr_fetch_unit.

Test Plan:
- Reset then fetch_en=1, instr_ready=1, memory loaded with mem[0]=32'h00500093, mem[1]=32'h00A00113:
  - instr_valid=1 with instr=32'h00500093, instr_pc=0, instr_pc_plus4=4.
  - Two cycles later instr=32'h00A00113, instr_pc=4.
- Backpressure:
  - instr_ready=0 for 5 cycles in VALID: instr and instr_pc stable, imem_addr constant.
  - instr_ready=1 on the 6th cycle: pc advances by exactly 4.
- Redirect:
  - redirect_valid=1, redirect_pc=32'h20 coincident with a handshake: next imem_addr=32'h20, instr_valid=0 for one cycle, then instr_pc=32'h20.
  - redirect_pc=32'h23 without the macro: fetch from 32'h20.
- Wrap-around: redirect to 32'hFFFF_FFFC, consume one instruction → imem_addr=32'h0000_0000.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously while in VALID.
  - Without waiting for a clock edge: instr_valid=0, instr=32'h00000013, imem_addr=RESET_PC.
- With FETCH_MISALIGN_TRAP_EN:
  - Redirect to 32'h0000_0006 → fetch_fault=1, instr_valid=0, state held.
  - Subsequent redirect to 32'h8 → fetch_fault=0, instr_pc=32'h8 two cycles later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state for misaligned redirect targets.
package fetch_pkg;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} fetch_state_e;
`else
    typedef enum logic [1:0] {IDLE, FETCH, VALID} fetch_state_e;
`endif

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with next-PC selection: redirect beats +4, otherwise hold.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Modulo 2^32: 32'hFFFF_FFFC wraps to zero.
    assign pc_plus4 = pc_q + 32'd4;
    assign pc       = pc_q;

    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (advance) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, latches the instruction word into IR, valid/ready to decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap into FAULT and raise fetch_fault.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        fetch_fault,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  target_pc;
    logic         redirect_bad;
    logic         advance;
    logic         capture;

`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned target is kept verbatim so the trap handler can see it.
    assign target_pc    = redirect_pc;
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc    = word_align(redirect_pc);
    assign redirect_bad = 1'b0;
`endif

    // Redirect wins: a coincident handshake consumes IR but drops the increment.
    assign advance = (state_q == VALID) && instr_ready && !redirect_valid;
    assign capture = (state_q == FETCH) && !redirect_valid;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .redirect    (redirect_valid),
        .redirect_pc (target_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_bad) begin
                state_d = FAULT;
            end else
`endif
            state_d = fetch_en ? FETCH : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en) state_d = FETCH;
                FETCH:   state_d = VALID;
                VALID:   if (instr_ready) state_d = fetch_en ? FETCH : IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        instr_valid = (state_q == VALID);
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault = (state_q == FAULT);
`endif
    end

    // IR is only written by a fetch that completes without being squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            instr_pc <= RESET_PC;
        end else if (capture) begin
            instr    <= imem_data;
            instr_pc <= pc;
        end
    end

    assign instr_pc_plus4 = instr_pc + 32'd4;

    logic unused_ok;
    assign unused_ok = redirect_bad;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, hand sequences,
// and randomized traffic against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign imem_data = mem[imem_addr[11:2]];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault    (fetch_fault),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] eaddr;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] eaddr, input logic [31:0] einstr,
                       input logic [31:0] epc);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.eaddr = eaddr; v.einstr = einstr; v.epc = epc;
        vecs.push_back(v);
    endtask

    // Behavioural model: pending fetch flag, valid IR, PC.
    logic [31:0] m_pc, m_ir, m_irpc;
    logic        m_valid, m_busy;

    task automatic model_step();
        if (redirect_valid) begin
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_valid = 1'b0;
            m_busy  = fetch_en;
        end else if (m_valid) begin
            if (instr_ready) begin
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b0;
                m_busy  = fetch_en;
            end
        end else if (m_busy) begin
            m_ir    = mem[m_pc[11:2]];
            m_irpc  = m_pc;
            m_valid = 1'b1;
            m_busy  = 1'b0;
        end else if (fetch_en) begin
            m_busy = 1'b1;
        end
    endtask

    task automatic drive(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        fetch_en       = fe;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] ODD_PC = 32'h20;
`else
    localparam logic [31:0] ODD_PC = 32'h23;
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00A0_0113;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        #12;
        check("reset_valid", {31'b0, instr_valid}, 32'd0);
        check("reset_instr", instr, 32'h0000_0013);
        check("reset_instr_pc", instr_pc, 32'h0);
        check("reset_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("reset_fault", {31'b0, fetch_fault}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        add(1, 1, 0, 32'h0,        0, 32'h0,        0,          0);
        add(1, 1, 0, 32'h0,        1, 32'h0,        mem[0],     32'h0);
        add(1, 1, 0, 32'h0,        0, 32'h4,        0,          0);
        add(1, 0, 0, 32'h0,        1, 32'h4,        mem[1],     32'h4);
        for (int i = 0; i < 5; i++)
            add(1, 0, 0, 32'h0,    1, 32'h4,        mem[1],     32'h4);
        add(1, 1, 0, 32'h0,        0, 32'h8,        0,          0);
        add(1, 1, 0, 32'h0,        1, 32'h8,        mem[2],     32'h8);
        add(1, 1, 1, 32'h20,       0, 32'h20,       0,          0);
        add(1, 0, 0, 32'h0,        1, 32'h20,       mem[8],     32'h20);
        add(1, 0, 1, ODD_PC,       0, 32'h20,       0,          0);
        add(1, 0, 0, 32'h0,        1, 32'h20,       mem[8],     32'h20);
        add(1, 0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0,        0);
        add(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, mem[1023], 32'hFFFF_FFFC);
        add(0, 1, 0, 32'h0,        0, 32'h0,        0,          0);
        add(0, 0, 0, 32'h0,        0, 32'h0,        0,          0);
        add(1, 0, 0, 32'h0,        0, 32'h0,        0,          0);
        add(0, 0, 0, 32'h0,        1, 32'h0,        mem[0],     32'h0);
        add(0, 1, 0, 32'h0,        0, 32'h4,        0,          0);
        add(0, 0, 0, 32'h0,        0, 32'h4,        0,          0);
        add(0, 0, 1, 32'h40,       0, 32'h40,       0,          0);
        add(0, 0, 0, 32'h0,        0, 32'h40,       0,          0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].eaddr);
            check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].ev});
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_instr", i), instr, vecs[i].einstr);
                check($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].epc);
                check($sformatf("vec%0d_pc_plus4", i), instr_pc_plus4, vecs[i].epc + 32'd4);
            end
        end

        // Asynchronous reset while holding a valid instruction at 0x40.
        drive(1, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("pre_reset_valid", {31'b0, instr_valid}, 32'd1);
        check("pre_reset_instr", instr, mem[16]);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, instr_valid}, 32'd0);
        check("async_reset_instr", instr, 32'h0000_0013);
        check("async_reset_addr", imem_addr, 32'h0);
        check("async_reset_instr_pc", instr_pc, 32'h0);
        drive(0, 0, 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1, 1, 1, 32'h6);
        @(posedge clk);
        #1;
        check("fault_set", {31'b0, fetch_fault}, 32'd1);
        check("fault_valid", {31'b0, instr_valid}, 32'd0);
        drive(1, 1, 0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("fault_held", {31'b0, fetch_fault}, 32'd1);
        check("fault_held_addr", imem_addr, 32'h6);
        drive(1, 0, 1, 32'h8);
        @(posedge clk);
        #1;
        check("fault_clear", {31'b0, fetch_fault}, 32'd0);
        drive(1, 0, 0, 32'h0);
        @(posedge clk);
        #1;
        check("fault_recover_valid", {31'b0, instr_valid}, 32'd1);
        check("fault_recover_pc", instr_pc, 32'h8);
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Randomized traffic against the model.
        m_pc = 32'h0; m_ir = 32'h13; m_irpc = 32'h0; m_valid = 1'b0; m_busy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? $urandom : {20'h0, 12'($urandom_range(0, 4095))};
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc[1:0] = 2'b00;
`endif
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 15) == 0), rpc);
            @(posedge clk);
            model_step();
            #1;
            check("rand_addr", imem_addr, m_pc);
            check("rand_valid", {31'b0, instr_valid}, {31'b0, m_valid});
            if (m_valid) begin
                check("rand_instr", instr, m_ir);
                check("rand_instr_pc", instr_pc, m_irpc);
                check("rand_pc_plus4", instr_pc_plus4, m_irpc + 32'd4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
